// File: rtl/bcd_serial_adder.sv
// Digit-serial multi-digit BCD adder: one bcd_one digit adder is reused once per clock, LSD first.
// Optional operand validity checking is built when BCD_SERIAL_CHECK_EN is defined.

module bcd_one (
    input  logic [3:0] i_a,
    input  logic [3:0] i_b,
    input  logic       i_c,
    output logic [3:0] o_s,
    output logic       o_cn
);
    logic [4:0] w_bin;

    assign w_bin = {1'b0, i_a} + {1'b0, i_b} + {4'b0000, i_c};
    assign o_cn  = (w_bin > 5'd9);
    // Adding 6 skips the six unused codes so the low nibble wraps back into 0..9.
    assign o_s   = o_cn ? (w_bin[3:0] + 4'd6) : w_bin[3:0];
endmodule

module bcd_serial_adder #(
    parameter int DIGITS = 4
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                start,
    input  logic [4*DIGITS-1:0] a,
    input  logic [4*DIGITS-1:0] b,
    input  logic                cin,
    output logic                busy,
    output logic                done,
    output logic [4*DIGITS-1:0] sum,
    output logic                cout,
    output logic                err
);
    localparam int W  = 4 * DIGITS;
    localparam int CW = (DIGITS > 1) ? $clog2(DIGITS) : 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(DIGITS - 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_RUN,
        S_DONE
    } state_t;

    state_t          r_state;
    state_t          w_next_state;
    logic [W-1:0]    r_a_sh;
    logic [W-1:0]    r_b_sh;
    logic [W-1:0]    r_sum_sh;
    logic [W-1:0]    w_sum_sh_next;
    logic [CW-1:0]   r_cnt;
    logic            r_carry;
    logic [W-1:0]    r_sum;
    logic            r_cout;
    logic [3:0]      w_digit;
    logic            w_cn;
    logic            w_capture;
    logic            w_last;

    assign w_capture = (r_state == S_IDLE) && start;
    assign w_last    = (r_state == S_RUN) && (r_cnt == CNT_LAST);

    bcd_one u_bcd_one (
        .i_a  (r_a_sh[3:0]),
        .i_b  (r_b_sh[3:0]),
        .i_c  (r_carry),
        .o_s  (w_digit),
        .o_cn (w_cn)
    );

    // Each new digit enters at the top so digit 0 ends up in the low nibble after DIGITS shifts.
    generate
        if (DIGITS == 1) begin : g_one_digit
            assign w_sum_sh_next = w_digit;
        end else begin : g_multi_digit
            assign w_sum_sh_next = {w_digit, r_sum_sh[W-1:4]};
        end
    endgenerate

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // NOTE: defaults are assigned first so no path through the case leaves a variable unassigned (no latch).
    always_comb begin
        w_next_state = r_state;
        case (r_state)
            S_IDLE:  if (start) w_next_state = S_RUN;
            S_RUN:   if (r_cnt == CNT_LAST) w_next_state = S_DONE;
            S_DONE:  w_next_state = S_IDLE;
            default: w_next_state = S_IDLE;
        endcase
    end

    // NOTE: these are plain registers, not a memory, so all of them are reset to a known value.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_a_sh   <= '0;
            r_b_sh   <= '0;
            r_sum_sh <= '0;
            r_carry  <= 1'b0;
            r_cnt    <= '0;
            r_sum    <= '0;
            r_cout   <= 1'b0;
        end else if (w_capture) begin
            r_a_sh   <= a;
            r_b_sh   <= b;
            r_carry  <= cin;
            r_cnt    <= '0;
            r_sum_sh <= '0;
        end else if (r_state == S_RUN) begin
            r_a_sh   <= r_a_sh >> 4;
            r_b_sh   <= r_b_sh >> 4;
            r_sum_sh <= w_sum_sh_next;
            r_carry  <= w_cn;
            if (r_cnt != CNT_LAST) begin
                r_cnt <= r_cnt + 1'b1;
            end
            // Results are taken from the next-state values so the final digit is included.
            if (w_last) begin
                r_sum  <= w_sum_sh_next;
                r_cout <= w_cn;
            end
        end
    end

`ifdef BCD_SERIAL_CHECK_EN
    logic w_bad_in;
    logic r_bad;
    logic r_err;

    always_comb begin
        w_bad_in = 1'b0;
        for (int i = 0; i < DIGITS; i++) begin
            if ((a[4*i +: 4] > 4'd9) || (b[4*i +: 4] > 4'd9)) begin
                w_bad_in = 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_bad <= 1'b0;
            r_err <= 1'b0;
        end else begin
            if (w_capture) begin
                r_bad <= w_bad_in;
            end
            if (w_last) begin
                r_err <= r_bad;
            end
        end
    end

    assign err = r_err;
`else
    assign err = 1'b0;
`endif

    assign busy = (r_state != S_IDLE);
    assign done = (r_state == S_DONE);
    assign sum  = r_sum;
    assign cout = r_cout;
endmodule

// File: tb/tb_bcd_serial_adder.sv
// Self-checking bench for bcd_serial_adder: DIGITS=4 and DIGITS=1 instances against a decimal reference model.
// Honours BCD_SERIAL_CHECK_EN for the expected err value.

module tb_bcd_serial_adder;
    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst;
    logic        start4, cin4, busy4, done4, cout4, err4;
    logic [15:0] a4, b4, sum4;
    logic        start1, cin1, busy1, done1, cout1, err1;
    logic [3:0]  a1, b1, sum1;

    int n_cmp = 0;
    int n_bad = 0;

`ifdef BCD_SERIAL_CHECK_EN
    localparam logic ERR_ON_BAD = 1'b1;
`else
    localparam logic ERR_ON_BAD = 1'b0;
`endif

    bcd_serial_adder #(.DIGITS(4)) dut4 (
        .clk(clk), .rst(rst), .start(start4), .a(a4), .b(b4), .cin(cin4),
        .busy(busy4), .done(done4), .sum(sum4), .cout(cout4), .err(err4)
    );

    bcd_serial_adder #(.DIGITS(1)) dut1 (
        .clk(clk), .rst(rst), .start(start1), .a(a1), .b(b1), .cin(cin1),
        .busy(busy1), .done(done1), .sum(sum1), .cout(cout1), .err(err1)
    );

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    // Decimal reference: convert to integers, add, reduce mod 10^digits, convert back.
    function automatic void ref_add(input int digits, input logic [63:0] a, input logic [63:0] b,
                                    input logic cin, output logic [63:0] s, output logic co);
        longint unsigned va = 0, vb = 0, p = 1, tot, r;
        for (int i = 0; i < digits; i++) begin
            va += 64'(a[4*i +: 4]) * p;
            vb += 64'(b[4*i +: 4]) * p;
            p  *= 10;
        end
        tot = va + vb + 64'(cin);
        co  = (tot >= p);
        r   = tot % p;
        s   = '0;
        for (int i = 0; i < digits; i++) begin
            s[4*i +: 4] = 4'(r % 10);
            r /= 10;
        end
    endfunction

    function automatic logic [63:0] rand_bcd(input int digits);
        logic [63:0] v = '0;
        for (int i = 0; i < digits; i++) v[4*i +: 4] = 4'($urandom_range(9));
        return v;
    endfunction

    // Issues one start on dut4; lat counts edges from the capture edge up to the done cycle.
    task automatic run4(input logic [15:0] a, input logic [15:0] b, input logic cin, output int lat);
        a4 = a; b4 = b; cin4 = cin; start4 = 1'b1;
        tick;
        start4 = 1'b0;
        lat = 1;
        while (done4 !== 1'b1 && lat < 40) begin
            tick;
            lat++;
        end
    endtask

    task automatic test_reset;
        rst = 1'b1;
        tick; tick;
        rst = 1'b0;
        n_cmp++; if (busy4 !== 1'b0) begin n_bad++; $display("FAIL reset_busy4: got %b want 0", busy4); end
        n_cmp++; if (done4 !== 1'b0) begin n_bad++; $display("FAIL reset_done4: got %b want 0", done4); end
        n_cmp++; if (sum4 !== 16'h0) begin n_bad++; $display("FAIL reset_sum4: got %h want 0000", sum4); end
        n_cmp++; if (cout4 !== 1'b0) begin n_bad++; $display("FAIL reset_cout4: got %b want 0", cout4); end
        n_cmp++; if (err4 !== 1'b0) begin n_bad++; $display("FAIL reset_err4: got %b want 0", err4); end
        n_cmp++; if ({busy1, done1, sum1, cout1} !== 7'b0) begin
            n_bad++; $display("FAIL reset_dut1: got busy=%b done=%b sum=%h cout=%b want all 0", busy1, done1, sum1, cout1);
        end
    endtask

    task automatic test_basic;
        int lat;
        a4 = 16'h1234; b4 = 16'h5678; cin4 = 1'b0; start4 = 1'b1;
        tick;
        start4 = 1'b0;
        lat = 1;
        while (done4 !== 1'b1 && lat < 40) begin
            n_cmp++; if (busy4 !== 1'b1) begin n_bad++; $display("FAIL basic_busy_run: cycle %0d got %b want 1", lat, busy4); end
            tick;
            lat++;
        end
        n_cmp++; if (lat !== 5) begin n_bad++; $display("FAIL basic_latency: got %0d want 5", lat); end
        n_cmp++; if (busy4 !== 1'b1) begin n_bad++; $display("FAIL basic_busy_done: got %b want 1", busy4); end
        n_cmp++; if (sum4 !== 16'h6912) begin n_bad++; $display("FAIL basic_sum: got %h want 6912", sum4); end
        n_cmp++; if (cout4 !== 1'b0) begin n_bad++; $display("FAIL basic_cout: got %b want 0", cout4); end
        n_cmp++; if (err4 !== 1'b0) begin n_bad++; $display("FAIL basic_err: got %b want 0", err4); end
        tick;
        n_cmp++; if (done4 !== 1'b0) begin n_bad++; $display("FAIL basic_done_pulse: got %b want 0", done4); end
        n_cmp++; if (busy4 !== 1'b0) begin n_bad++; $display("FAIL basic_busy_idle: got %b want 0", busy4); end
        n_cmp++; if (sum4 !== 16'h6912) begin n_bad++; $display("FAIL basic_sum_hold: got %h want 6912", sum4); end
    endtask

    task automatic test_carry;
        logic [15:0] ta [2] = '{16'h9999, 16'h4999};
        logic [15:0] tb [2] = '{16'h0001, 16'h5000};
        logic        tc [2] = '{1'b0, 1'b1};
        int lat;
        for (int i = 0; i < 2; i++) begin
            run4(ta[i], tb[i], tc[i], lat);
            n_cmp++; if (sum4 !== 16'h0000) begin n_bad++; $display("FAIL carry_sum[%0d]: got %h want 0000", i, sum4); end
            n_cmp++; if (cout4 !== 1'b1) begin n_bad++; $display("FAIL carry_cout[%0d]: got %b want 1", i, cout4); end
            tick;
        end
    endtask

    task automatic test_random;
        logic [63:0] ra, rb, es;
        logic        rc, ec;
        int lat;
        for (int n = 0; n < 25; n++) begin
            ra = rand_bcd(4); rb = rand_bcd(4); rc = 1'($urandom_range(1));
            ref_add(4, ra, rb, rc, es, ec);
            run4(ra[15:0], rb[15:0], rc, lat);
            n_cmp++; if (lat !== 5) begin n_bad++; $display("FAIL rand_latency[%0d]: got %0d want 5", n, lat); end
            n_cmp++; if (sum4 !== es[15:0]) begin
                n_bad++; $display("FAIL rand_sum[%0d]: %h+%h+%b got %h want %h", n, ra[15:0], rb[15:0], rc, sum4, es[15:0]);
            end
            n_cmp++; if (cout4 !== ec) begin n_bad++; $display("FAIL rand_cout[%0d]: got %b want %b", n, cout4, ec); end
            n_cmp++; if (err4 !== 1'b0) begin n_bad++; $display("FAIL rand_err[%0d]: got %b want 0", n, err4); end
            // Random idle gap before the next operation.
            for (int g = 0; g < 1 + int'($urandom_range(2)); g++) tick;
        end
    endtask

    task automatic test_back_to_back;
        int last_done = 0;
        int n_done = 0;
        logic [15:0] prev_sum;
        prev_sum = sum4;
        a4 = 16'h0005; b4 = 16'h0005; cin4 = 1'b0; start4 = 1'b1;
        tick;
        for (int c = 1; c < 40 && n_done < 3; c++) begin
            if (done4 === 1'b1) begin
                n_done++;
                n_cmp++; if (c - last_done !== (n_done == 1 ? 5 : 6)) begin
                    n_bad++; $display("FAIL b2b_interval[%0d]: got %0d want %0d", n_done, c - last_done, n_done == 1 ? 5 : 6);
                end
                n_cmp++; if (sum4 !== 16'h0010) begin n_bad++; $display("FAIL b2b_sum[%0d]: got %h want 0010", n_done, sum4); end
                last_done = c;
                prev_sum = sum4;
            end else begin
                n_cmp++; if (sum4 !== prev_sum) begin n_bad++; $display("FAIL b2b_sum_stable: cycle %0d got %h want %h", c, sum4, prev_sum); end
            end
            if (n_done < 3) tick;
        end
        start4 = 1'b0;
        n_cmp++; if (n_done !== 3) begin n_bad++; $display("FAIL b2b_count: got %0d want 3", n_done); end
        tick; tick;
    endtask

    task automatic test_reset_abort;
        int lat;
        a4 = 16'h1111; b4 = 16'h2222; cin4 = 1'b0; start4 = 1'b1;
        tick;
        start4 = 1'b0;
        tick;
        rst = 1'b1;
        tick;
        rst = 1'b0;
        n_cmp++; if (busy4 !== 1'b0) begin n_bad++; $display("FAIL abort_busy: got %b want 0", busy4); end
        n_cmp++; if (sum4 !== 16'h0) begin n_bad++; $display("FAIL abort_sum: got %h want 0000", sum4); end
        n_cmp++; if (cout4 !== 1'b0) begin n_bad++; $display("FAIL abort_cout: got %b want 0", cout4); end
        for (int c = 0; c < 6; c++) begin
            n_cmp++; if (done4 !== 1'b0) begin n_bad++; $display("FAIL abort_no_done: cycle %0d got %b want 0", c, done4); end
            tick;
        end
        run4(16'h1111, 16'h2222, 1'b0, lat);
        n_cmp++; if (lat !== 5) begin n_bad++; $display("FAIL abort_restart_lat: got %0d want 5", lat); end
        n_cmp++; if (sum4 !== 16'h3333) begin n_bad++; $display("FAIL abort_restart_sum: got %h want 3333", sum4); end
        tick;
    endtask

    task automatic test_check;
        int lat;
        run4(16'h12F4, 16'h0001, 1'b0, lat);
        n_cmp++; if (err4 !== ERR_ON_BAD) begin n_bad++; $display("FAIL check_err_bad: got %b want %b", err4, ERR_ON_BAD); end
        tick;
        run4(16'h0001, 16'h0001, 1'b0, lat);
        n_cmp++; if (err4 !== 1'b0) begin n_bad++; $display("FAIL check_err_clear: got %b want 0", err4); end
        n_cmp++; if (sum4 !== 16'h0002) begin n_bad++; $display("FAIL check_sum: got %h want 0002", sum4); end
        tick;
    endtask

    task automatic test_digits1;
        logic [63:0] ra, rb, es;
        logic        rc, ec;
        int lat;
        for (int n = 0; n < 8; n++) begin
            if (n == 0) begin
                ra = 64'h7; rb = 64'h8; rc = 1'b1;
            end else begin
                ra = rand_bcd(1); rb = rand_bcd(1); rc = 1'($urandom_range(1));
            end
            ref_add(1, ra, rb, rc, es, ec);
            a1 = ra[3:0]; b1 = rb[3:0]; cin1 = rc; start1 = 1'b1;
            tick;
            start1 = 1'b0;
            lat = 1;
            while (done1 !== 1'b1 && lat < 20) begin
                tick;
                lat++;
            end
            n_cmp++; if (lat !== 2) begin n_bad++; $display("FAIL d1_latency[%0d]: got %0d want 2", n, lat); end
            n_cmp++; if (sum1 !== es[3:0]) begin
                n_bad++; $display("FAIL d1_sum[%0d]: %h+%h+%b got %h want %h", n, ra[3:0], rb[3:0], rc, sum1, es[3:0]);
            end
            n_cmp++; if (cout1 !== ec) begin n_bad++; $display("FAIL d1_cout[%0d]: got %b want %b", n, cout1, ec); end
            tick;
        end
    endtask

    initial begin
        rst = 1'b1;
        start4 = 1'b0; a4 = '0; b4 = '0; cin4 = 1'b0;
        start1 = 1'b0; a1 = '0; b1 = '0; cin1 = 1'b0;
        test_reset;
        test_basic;
        test_carry;
        test_random;
        test_back_to_back;
        test_reset_abort;
        test_check;
        test_digits1;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
